// File: rtl/data_memory_lsu.sv
// rtl/data_memory_lsu.sv - MEM-stage data memory with valid/ready request/response handshake
//
// Purpose:
//   Word-organised RAM of DEPTH_WORDS 32-bit words. Supports byte, half and word stores
//   and sign- or zero-extending loads. A request is accepted on a valid/ready handshake.
//   Its single response appears on the following cycle and is held until consumed.
//   Responses leave in request order.
//
// Optional feature:
//   DMEM_MISALIGN_EXC_EN - when defined, a misaligned half or word access is rejected
//   with resp_err. When undefined, the unused low address bits are ignored.
//
// Ports:
//   i_clk           clock, all state on rising edge
//   i_rst_n         asynchronous active-low reset
//   i_req_valid     request present
//   o_req_ready     request accepted when i_req_valid && o_req_ready
//   i_req_we        1 = store, 0 = load
//   i_req_size      00 byte, 01 half, 10 word, 11 reserved (error)
//   i_req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   i_req_addr      byte address
//   i_req_wdata     right-justified store data
//   o_resp_valid    response present, held until i_resp_ready
//   i_resp_ready    consumer accepts response
//   o_resp_rdata    extended load data; 0 for stores and errors
//   o_resp_err      out of range / reserved size / misaligned

module data_memory_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [31:0]       o_resp_rdata,
    output logic              o_resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic [AW-1:0] w_idx;
    logic          w_oor;
    logic          w_size_bad;
    logic          w_misalign;
    logic          w_err;
    logic [31:0]   w_word;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_rep;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load_data;
    logic [31:0]   w_resp_rdata_next;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_accept   = i_req_valid && o_req_ready;
    assign w_idx      = i_req_addr[AW+1:2];
    // Any set bit above the word index lands outside the array.
    assign w_oor      = |(i_req_addr >> (AW + 2));
    assign w_size_bad = (i_req_size == 2'b11);

`ifdef DMEM_MISALIGN_EXC_EN
    assign w_misalign = ((i_req_size == 2'b01) && i_req_addr[0]) ||
                        ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err  = w_oor || w_size_bad || w_misalign;

    // Asynchronous array read; the result is captured into the response
    // register on the accept edge, giving one cycle of read latency. A
    // load issued right after a store to the same word sees the new data
    // because the store has already landed in the array at that edge.
    assign w_word = r_mem[w_idx];

    // ------------------------------------------------------------------
    // Store lane strobes and replicated write data
    // ------------------------------------------------------------------
    always_comb begin
        w_be        = 4'b0000;
        w_wdata_rep = i_req_wdata;
        case (i_req_size)
            2'b00: begin
                w_be        = 4'b0001 << i_req_addr[1:0];
                w_wdata_rep = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = i_req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{i_req_wdata[15:0]}};
            end
            2'b10: begin
                w_be        = 4'b1111;
                w_wdata_rep = i_req_wdata;
            end
            default: begin
                w_be        = 4'b0000;
                w_wdata_rep = i_req_wdata;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_accept && i_req_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load lane select and extension
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = w_word[7:0];
        case (i_req_addr[1:0])
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    assign w_half = i_req_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_data = 32'h0;
        case (i_req_size)
            2'b00:   w_load_data = i_req_unsigned ? {24'h0, w_byte}
                                                  : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_data = i_req_unsigned ? {16'h0, w_half}
                                                  : {{16{w_half[15]}}, w_half};
            2'b10:   w_load_data = w_word;
            default: w_load_data = 32'h0;
        endcase
    end

    assign w_resp_rdata_next = (w_err || i_req_we) ? 32'h0 : w_load_data;

    // ------------------------------------------------------------------
    // Response FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_resp_rdata <= w_resp_rdata_next;
                r_resp_err   <= w_err;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_resp_valid = 1'b0;
        o_req_ready  = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_resp_valid = 1'b0;
                o_req_ready  = 1'b1;
                if (w_accept) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                // A new request may enter in the same cycle the held
                // response is consumed, sustaining one request per cycle.
                o_req_ready  = i_resp_ready;
                if (w_accept) begin
                    w_state_next = S_RESP;
                end else if (i_resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb/tb_data_memory_lsu.sv - self-checking bench for data_memory_lsu

module tb_data_memory_lsu;

    localparam int DEPTH = 256;
    localparam int AMAX  = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    data_memory_lsu #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_W      (32)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_resp_valid   (resp_valid),
        .i_resp_ready   (resp_ready),
        .o_resp_rdata   (resp_rdata),
        .o_resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    // ------------------------------------------------------------------
    // Byte-addressed reference model and expected-response queue
    // ------------------------------------------------------------------
    logic [7:0]  mem_m [AMAX];
    logic [31:0] q_rd[$];
    logic        q_err[$];

    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rd, output logic er);
        int nb;
        int a;
        logic [31:0] v;
        rd = 32'h0;
        er = 1'b0;
        if (addr >= AMAX || size == 2'b11) begin
            er = 1'b1;
            return;
        end
        nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
`ifdef DMEM_MISALIGN_EXC_EN
        if ((int'(addr) % nb) != 0) begin
            er = 1'b1;
            return;
        end
`endif
        a = int'(addr) - (int'(addr) % nb);
        if (we) begin
            for (int k = 0; k < nb; k++) mem_m[a+k] = wdata[8*k +: 8];
            return;
        end
        v = 32'h0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = mem_m[a+k];
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8*nb)) - 32'h1);
        rd = v;
    endfunction

    // One clock of the randomised pump: drive, observe, score, advance.
    task automatic cycle(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic rr);
        logic        take;
        logic        acc;
        logic        exp_ready;
        logic [31:0] rd;
        logic        er;
        @(negedge clk);
        req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; resp_ready = rr;
        #1;
        exp_ready = (q_rd.size() == 0) || rr;
        check("rnd resp_valid", {31'h0, resp_valid}, {31'h0, q_rd.size() != 0});
        check("rnd req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
        take = resp_valid && rr;
        acc  = v && req_ready;
        if (take) begin
            if (q_rd.size() == 0) begin
                check("rnd unexpected response", 32'h1, 32'h0);
            end else begin
                check("rnd rdata", resp_rdata, q_rd[0]);
                check("rnd err", {31'h0, resp_err}, {31'h0, q_err[0]});
                void'(q_rd.pop_front());
                void'(q_err.pop_front());
            end
        end
        if (acc) begin
            model(we, sz, uns, addr, wdata, rd, er);
            q_rd.push_back(rd);
            q_err.push_back(er);
        end
        @(posedge clk);
    endtask

    logic [31:0] last_addr;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
        last_addr = 32'h0;

        // reset state
        #12;
        check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        check("reset resp_err", {31'h0, resp_err}, 32'h0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset req_ready", {31'h0, req_ready}, 32'h1);

        // directed table
        add(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        add(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        add(0, 2'b00, 1, 32'h13, 32'h0, 32'h000000DE, 0);
        add(0, 2'b00, 0, 32'h11, 32'h0, 32'hFFFFFFBE, 0);
        add(0, 2'b01, 0, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
        add(0, 2'b01, 1, 32'h10, 32'h0, 32'h0000BEEF, 0);
        add(1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0);
        add(1, 2'b00, 0, 32'h21, 32'hFFFFFF5A, 32'h0, 0);
        add(0, 2'b10, 0, 32'h20, 32'h0, 32'h11225A44, 0);
        add(1, 2'b01, 0, 32'h22, 32'hABCD7788, 32'h0, 0);
        add(0, 2'b10, 0, 32'h20, 32'h0, 32'h77885A44, 0);
        add(1, 2'b10, 0, 32'h0, 32'hCAFEF00D, 32'h0, 0);
        add(0, 2'b10, 0, AMAX, 32'h0, 32'h0, 1);
        add(1, 2'b10, 0, AMAX, 32'hFFFFFFFF, 32'h0, 1);
        add(0, 2'b10, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0);
        add(0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1);
        add(1, 2'b11, 0, 32'h0, 32'h12345678, 32'h0, 1);
        add(0, 2'b10, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0);
        add(0, 2'b00, 0, 32'h80000000, 32'h0, 32'h0, 1);
`ifdef DMEM_MISALIGN_EXC_EN
        add(0, 2'b10, 0, 32'h21, 32'h0, 32'h0, 1);
        add(0, 2'b01, 0, 32'h23, 32'h0, 32'h0, 1);
`else
        add(0, 2'b10, 0, 32'h21, 32'h0, 32'h77885A44, 0);
        add(0, 2'b01, 0, 32'h23, 32'h0, 32'h00007788, 0);
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = vecs[i].we; req_size = vecs[i].size;
            req_unsigned = vecs[i].uns; req_addr = vecs[i].addr;
            req_wdata = vecs[i].wdata; resp_ready = 1'b1;
            #1;
            check($sformatf("vec%0d req_ready", i), {31'h0, req_ready}, 32'h1);
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            check($sformatf("vec%0d resp_valid", i), {31'h0, resp_valid}, 32'h1);
            check($sformatf("vec%0d rdata", i), resp_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d err", i), {31'h0, resp_err}, {31'h0, vecs[i].exp_err});
            @(posedge clk);
        end

        // back-pressure: three loads, consumer stalled for four cycles
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h10; resp_ready = 1'b0;
        #1;
        check("bp first req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h20;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("bp stall%0d req_ready", k), {31'h0, req_ready}, 32'h0);
            check($sformatf("bp stall%0d resp_valid", k), {31'h0, resp_valid}, 32'h1);
            check($sformatf("bp stall%0d rdata", k), resp_rdata, 32'hDEADBEEF);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        check("bp release req_ready", {31'h0, req_ready}, 32'h1);
        check("bp resp0", resp_rdata, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h0;
        #1;
        check("bp resp1 valid", {31'h0, resp_valid}, 32'h1);
        check("bp resp1", resp_rdata, 32'h77885A44);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("bp resp2 valid", {31'h0, resp_valid}, 32'h1);
        check("bp resp2", resp_rdata, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("bp drained", {31'h0, resp_valid}, 32'h0);

        // reset asserted while a response is held
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("mid-reset held valid", {31'h0, resp_valid}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid-reset resp_valid", {31'h0, resp_valid}, 32'h0);
        check("mid-reset resp_err", {31'h0, resp_err}, 32'h0);
        check("mid-reset resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        #1;
        check("post-reset req_ready", {31'h0, req_ready}, 32'h1);
        check("post-reset resp_valid", {31'h0, resp_valid}, 32'h0);

        // randomised: fill every word, then mixed traffic against the model
        for (int w = 0; w < DEPTH; w++) begin
            cycle(1'b1, 1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, 1'b1);
        end
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int          r;
            r = $urandom_range(0, 15);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = AMAX + $urandom_range(0, 15);
            else if (r < 6)  a = (last_addr & ~32'h3) | 32'($urandom_range(0, 3));
            else             a = $urandom_range(0, AMAX - 1);
            r = $urandom_range(0, 7);
            sz = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, sz,
                  $urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 3) != 0);
            if (a < AMAX) last_addr = a;
        end
        cycle(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        check("final queue empty", 32'(q_rd.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
